// File: rtl/mem_sweep_checker_if.sv
// Block-RAM port bundle between the sweep checker (master) and the memory (slave).
// The memory has one read and one write port; dout is registered one cycle after raddr.
interface mem_sweep_checker_if #(
  parameter int WID_MEM = 4
);
  logic [31:0]        raddr;
  logic [31:0]        waddr;
  logic [WID_MEM-1:0] din;
  logic [WID_MEM-1:0] dout;

  modport master (output raddr, output waddr, output din, input dout);
  modport slave  (input raddr, input waddr, input din, output dout);
endinterface

// File: rtl/mem_sweep_checker.sv
// Non-destructive readback sweep of a bitstream-loaded block RAM: every word is read,
// written back unchanged one cycle later, and folded into a rotate-xor checksum.
module mem_sweep_checker #(
  parameter int WID_MEM      = 4,   // must not exceed 32
  parameter int DEPTH_MEM    = 4096,
  parameter int SCRATCH_ADDR = DEPTH_MEM - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          golden,
  mem_sweep_checker_if.master  mem,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          checksum,
  output logic                 match
);

  localparam int              AW      = (DEPTH_MEM > 1) ? $clog2(DEPTH_MEM) : 1;
  localparam logic [31:0]     SCRATCH = 32'(SCRATCH_ADDR);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH_MEM - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] addr;
  logic [AW-1:0] wb_addr;
  logic          wb_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem.raddr = SCRATCH;
    unique case (state)
      IDLE:  if (start) state_nx = SCAN;
      SCAN: begin
        busy      = 1'b1;
        mem.raddr = 32'(addr);
        if (addr == LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nx = SCAN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read at cycle t lands on dout at t+1 and is written straight back to wb_addr, so
  // the write port always trails the read port by exactly one address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      wb_addr  <= '0;
      wb_valid <= 1'b0;
      checksum <= '0;
    end else begin
      if (wb_valid) checksum <= {checksum[30:0], checksum[31]} ^ 32'(mem.dout);
      unique case (state)
        IDLE, DONE: if (start) begin
          addr     <= '0;
          checksum <= '0;
        end
        SCAN: begin
          addr     <= addr + AW'(1);
          wb_addr  <= addr;
          wb_valid <= 1'b1;
        end
        DRAIN:   wb_valid <= 1'b0;
        default: wb_valid <= 1'b0;
      endcase
    end
  end

  // The memory writes every cycle; when idle it parks on the scratch word and zeroes it.
  assign mem.waddr = wb_valid ? 32'(wb_addr) : SCRATCH;
  assign mem.din   = wb_valid ? mem.dout : '0;
  assign match     = done && (checksum == golden);

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Bench for mem_sweep_checker: a 4-word instance driven from a vector table and a
// default 4096-word instance checked against a checksum model on random contents.
module tb_mem_sweep_checker;

  localparam int DEPTH_S = 4;
  localparam int DEPTH_D = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- small instance: DEPTH 4, scratch = 3 ----------------
  logic        start_s, busy_s, done_s, match_s, load_s;
  logic [31:0] golden_s, checksum_s;
  logic [3:0]  mem_s [DEPTH_S];
  logic [3:0]  img_s [DEPTH_S];
  logic [3:0]  wd_s  [DEPTH_S];

  mem_sweep_checker_if #(.WID_MEM(4)) bus_s ();
  mem_sweep_checker #(.WID_MEM(4), .DEPTH_MEM(DEPTH_S)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .golden(golden_s), .mem(bus_s),
    .busy(busy_s), .done(done_s), .checksum(checksum_s), .match(match_s));

  always @(posedge clk) begin
    if (load_s) mem_s <= img_s;
    else begin
      bus_s.dout <= mem_s[bus_s.raddr[1:0]];
      mem_s[bus_s.waddr[1:0]] <= bus_s.din;
    end
  end

  // ---------------- default instance: DEPTH 4096, scratch = 4095 ----------------
  logic        start_d, busy_d, done_d, match_d, load_d;
  logic [31:0] golden_d, checksum_d;
  logic [3:0]  mem_d [DEPTH_D];
  logic [3:0]  img_d [DEPTH_D];
  logic [3:0]  wd_d  [DEPTH_D];

  mem_sweep_checker_if #(.WID_MEM(4)) bus_d ();
  mem_sweep_checker dut_d (
    .clk(clk), .reset(reset), .start(start_d), .golden(golden_d), .mem(bus_d),
    .busy(busy_d), .done(done_d), .checksum(checksum_d), .match(match_d));

  always @(posedge clk) begin
    if (load_d) mem_d <= img_d;
    else begin
      bus_d.dout <= mem_d[bus_d.raddr[11:0]];
      mem_d[bus_d.waddr[11:0]] <= bus_d.din;
    end
  end

  // Reference checksum: fold the words in address order, scratch word counted as 0.
  function automatic logic [31:0] model_d();
    logic [31:0] c = 32'h0;
    for (int i = 0; i < DEPTH_D; i++) c = ((c << 1) | (c >> 31)) ^ 32'(wd_d[i]);
    return c;
  endfunction

  // Both sweep tasks are entered just after a negedge; lat counts edges after the start edge.
  task automatic sweep_s(input bit repulse, output int lat, output int bad);
    lat = -1; bad = 0;
    start_s = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= DEPTH_S + 6; e++) begin
      if (e > 0) @(posedge clk);
      @(negedge clk);
      if (e == 0) start_s = 1'b0;
      if (repulse) start_s = (e == 2);
      if (e < DEPTH_S && bus_s.raddr !== 32'(e)) bad++;
      if (e >= 1 && e <= DEPTH_S &&
          (bus_s.waddr !== 32'(e - 1) || bus_s.din !== wd_s[e-1])) bad++;
      if (e <= DEPTH_S && busy_s !== 1'b1) bad++;
      if (done_s) begin lat = e; break; end
    end
    start_s = 1'b0;
  endtask

  task automatic sweep_d(output int lat, output int bad);
    lat = -1; bad = 0;
    start_d = 1'b1;
    @(posedge clk);
    for (int e = 0; e <= DEPTH_D + 6; e++) begin
      if (e > 0) @(posedge clk);
      @(negedge clk);
      if (e == 0) start_d = 1'b0;
      if (e < DEPTH_D && bus_d.raddr !== 32'(e)) bad++;
      if (e >= 1 && e <= DEPTH_D &&
          (bus_d.waddr !== 32'(e - 1) || bus_d.din !== wd_d[e-1])) bad++;
      if (e <= DEPTH_D && busy_d !== 1'b1) bad++;
      if (done_d) begin lat = e; break; end
    end
  endtask

  task automatic load_img_s();
    load_s = 1'b1;
    @(negedge clk);
    load_s = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic load_img_d();
    load_d = 1'b1;
    @(negedge clk);
    load_d = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_d(input string tag);
    int lat, bad, mem_bad;
    logic [31:0] exp_cs;
    exp_cs   = model_d();
    golden_d = exp_cs;
    sweep_d(lat, bad);
    mem_bad = 0;
    for (int i = 0; i < DEPTH_D; i++) if (mem_d[i] !== wd_d[i]) mem_bad++;
    check({tag, "_latency"},  32'(lat), 32'(DEPTH_D + 1));
    check({tag, "_sequence"}, 32'(bad), 32'h0);
    check({tag, "_checksum"}, checksum_d, exp_cs);
    check({tag, "_match"},    32'(match_d), 32'h1);
    check({tag, "_mem_kept"}, 32'(mem_bad), 32'h0);
  endtask

  // Vector table for the small instance: pre holds words 3..0 (word 0 in the low nibble).
  typedef struct {
    logic [15:0] pre;
    logic [31:0] golden;
    logic [31:0] exp_cs;
    bit          exp_match;
    bit          repulse;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int lat, bad;
    logic [15:0] got;
    logic [31:0] first_cs;

    reset = 1'b0; start_s = 1'b0; start_d = 1'b0; load_s = 1'b0; load_d = 1'b0;
    golden_s = '0; golden_d = '0;

    vecs[0] = '{16'hF321, 32'h6,  32'h6,  1'b1, 1'b0};
    vecs[1] = '{16'hF321, 32'h7,  32'h6,  1'b0, 1'b0};
    vecs[2] = '{16'hF321, 32'h6,  32'h6,  1'b1, 1'b1};
    vecs[3] = '{16'h5904, 32'h32, 32'h32, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 32'h0,  32'h5A, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_raddr",    bus_s.raddr, 32'd3);
    check("rst_waddr",    bus_s.waddr, 32'd3);
    check("rst_din",      32'(bus_s.din), 32'h0);
    check("rst_flags",    {29'h0, busy_s, done_s, match_s}, 32'h0);
    check("rst_checksum", checksum_s, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      for (int a = 0; a < DEPTH_S; a++) img_s[a] = vecs[i].pre[a*4 +: 4];
      wd_s = img_s;
      wd_s[DEPTH_S-1] = 4'h0;
      golden_s = vecs[i].golden;
      load_img_s();
      sweep_s(vecs[i].repulse, lat, bad);
      got = {mem_s[3], mem_s[2], mem_s[1], mem_s[0]};
      check($sformatf("v%0d_latency", i),  32'(lat), 32'(DEPTH_S + 1));
      check($sformatf("v%0d_sequence", i), 32'(bad), 32'h0);
      check($sformatf("v%0d_checksum", i), checksum_s, vecs[i].exp_cs);
      check($sformatf("v%0d_match", i),    32'(match_s), 32'(vecs[i].exp_match));
      check($sformatf("v%0d_done", i),     32'(done_s), 32'h1);
      check($sformatf("v%0d_mem_after", i), 32'(got), 32'({4'h0, vecs[i].pre[11:0]}));
    end

    // Reset in the middle of a sweep, once the checksum is already non-zero.
    golden_s = 32'h0;
    start_s  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_pre_reset_busy", 32'(busy_s), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_raddr",    bus_s.raddr, 32'd3);
    check("mid_rst_waddr",    bus_s.waddr, 32'd3);
    check("mid_rst_din",      32'(bus_s.din), 32'h0);
    check("mid_rst_flags",    {29'h0, busy_s, done_s, match_s}, 32'h0);
    check("mid_rst_checksum", checksum_s, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {30'h0, busy_s, done_s}, 32'h0);

    // Default-size instance: all 0xF, then random contents swept twice.
    for (int i = 0; i < DEPTH_D; i++) img_d[i] = 4'hF;
    wd_d = img_d;
    wd_d[DEPTH_D-1] = 4'h0;
    load_img_d();
    run_d("allF");

    for (int i = 0; i < DEPTH_D; i++) img_d[i] = 4'($urandom_range(0, 15));
    wd_d = img_d;
    wd_d[DEPTH_D-1] = 4'h0;
    load_img_d();
    run_d("rand1");
    first_cs = checksum_d;
    @(negedge clk);
    run_d("rand2");
    check("rand_repeat_same", checksum_d, first_cs);
    golden_d = first_cs ^ 32'h1;
    #1;
    check("rand_wrong_golden", 32'(match_d), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_sweep_checker.md
Name: mem_sweep_checker

Overview:
Sits directly upstream of the block-RAM memory and drives all of its ports: raddr, waddr and din in, dout back.
On start, it sweeps every address once, reading each word and writing the same word back unchanged (non-destructive, since the memory writes every cycle). It folds the read data into a 32-bit checksum and flags a match against a golden value.
Its purpose is post-reinit readback verification of bitstream-loaded memory contents.

Parameters:
WID_MEM, 4, data width of the memory word.
DEPTH_MEM, 4096, number of memory words; swept addresses are 0..DEPTH_MEM-1.
SCRATCH_ADDR, DEPTH_MEM-1, parked address while not sweeping; its contents are destroyed (overwritten with 0).

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset (0 = reset).
start  in  1  single-cycle request to begin a sweep.
golden  in  32  expected checksum, sampled at the end of the sweep.
raddr  out  32  memory read address.
waddr  out  32  memory write address.
din  out  WID_MEM  memory write data.
dout  in  WID_MEM  memory read data; valid one cycle after raddr.
busy  out  1  high in SCAN and DRAIN.
done  out  1  high in DONE.
checksum  out  32  running/final checksum.
match  out  1  done && checksum==golden.

Behaviour:
- Reset (reset=0, async): state=IDLE, addr=0, wb_valid=0, wb_addr=0, checksum=0.
  - Outputs during and after reset: raddr=waddr=SCRATCH_ADDR, din=0, busy=0, done=0, match=0.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - raddr=waddr=SCRATCH_ADDR, din=0.
  - start=1 at edge E0: go to SCAN, addr=0, checksum=0.
- SCAN:
  - raddr=addr.
  - Each edge: addr+1; wb_addr<=addr; wb_valid<=1.
  - At the edge where addr==DEPTH_MEM-1: go to DRAIN.
- Writeback path (registered, all states):
  - waddr = wb_valid ? wb_addr : SCRATCH_ADDR.
  - din = wb_valid ? dout : 0.
  - The word read at cycle t is written back to the same address at cycle t+1.
  - No address collision: the write address always trails the read address by one.
- Checksum: on each edge where wb_valid=1, checksum <= {checksum[30:0],checksum[31]} ^ zero_extend(dout).
  - WID_MEM > 32 is unsupported.
- DRAIN:
  - raddr=SCRATCH_ADDR.
  - The last word is written back and accumulated this cycle.
  - Next edge: wb_valid<=0, state=DONE.
- DONE:
  - done=1; checksum is held.
  - match = (checksum==golden), evaluated combinationally.
  - Addresses and din are parked as in IDLE.
  - start=1 begins a new sweep exactly as from IDLE and clears checksum.
- Latency: start edge E0 -> done=1 after edge E0+DEPTH_MEM+1. One word per cycle, no stalls.
- start while busy: ignored; the sweep is not restarted.
- Reset asserted mid-sweep: immediate return to IDLE. The in-flight writeback is abandoned and no partial result is reported.
- Address counter width: clog2(DEPTH_MEM), zero-extended to 32 bits on raddr/waddr.
- SCRATCH_ADDR is included in the sweep; its word reads as 0.

Test Plan:
- Reset with reset=0 mid-operation -> raddr=waddr=SCRATCH_ADDR, din=0, busy=done=match=checksum=0, all in the same cycle as assertion.
- DEPTH_MEM=4, WID_MEM=4, SCRATCH_ADDR=3, memory preloaded {1,2,3,F}, start pulse -> raddr 0,1,2,3 on successive cycles; writes (0,1),(1,2),(2,3),(3,0); checksum=0x00000006; done 5 edges after start; memory afterwards {1,2,3,0}.
- Same sweep with golden=0x6 -> match=1; with golden=0x7 -> match=0, done=1.
- start re-pulsed during SCAN -> ignored; done still appears at E0+DEPTH_MEM+1 with an unchanged checksum.
- Default parameters, memory all 0xF except scratch -> 4096 sequential raddr values. Every written word equals the word read one cycle earlier at the same address; bench model checksum equals the DUT checksum.
- Second start from DONE -> checksum cleared, identical result to the first sweep (non-destructive check).
